// File: rtl/pipe_pkg.sv
// Shared widths, control-bundle bit map and state encoding for pipeline stage registers.
package pipe_pkg;

  localparam int unsigned DATA_W_D   = 16;
  localparam int unsigned NUM_DATA_D = 4;
  localparam int unsigned RD_W_D     = 4;
  localparam int unsigned CTRL_W_D   = 8;
  localparam int unsigned CNT_W_D    = 16;

  // Control bundle bit positions
  localparam int unsigned CTRL_PCWRITE    = 0;
  localparam int unsigned CTRL_MEM2REG    = 1;
  localparam int unsigned CTRL_MEMWRITE   = 2;
  localparam int unsigned CTRL_ALUSRC     = 3;
  localparam int unsigned CTRL_ALUIN1_LSB = 4;
  localparam int unsigned CTRL_ALUIN1_MSB = 5;
  localparam int unsigned CTRL_ALUIN2_LSB = 6;
  localparam int unsigned CTRL_ALUIN2_MSB = 7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake and payload bundle between two pipeline stages, plus the stage's stall counter.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_D,
  parameter int unsigned NUM_DATA = NUM_DATA_D,
  parameter int unsigned RD_W     = RD_W_D,
  parameter int unsigned CTRL_W   = CTRL_W_D,
  parameter int unsigned CNT_W    = CNT_W_D
);

  localparam int unsigned PAY_W = NUM_DATA * DATA_W;

  logic              in_valid;
  logic              in_ready;
  logic [PAY_W-1:0]  in_data;
  logic [RD_W-1:0]   in_rd;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PAY_W-1:0]  out_data;
  logic [RD_W-1:0]   out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  // Upstream/hazard/downstream side driving the stage
  modport master (
    output in_valid, in_data, in_rd, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_data, out_rd, out_ctrl, stall_cnt
  );

  // The stage register itself
  modport slave (
    input  in_valid, in_data, in_rd, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_data, out_rd, out_ctrl, stall_cnt
  );

endinterface

// File: rtl/pipe_entry.sv
// One payload slot (data + rd + ctrl + valid). Clear drops the beat and zeroes rd/ctrl so
// an empty slot never presents write-enables; data is left stale.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned PAY_W  = NUM_DATA_D * DATA_W_D,
  parameter int unsigned RD_W   = RD_W_D,
  parameter int unsigned CTRL_W = CTRL_W_D
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [PAY_W-1:0]  data_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [PAY_W-1:0]  data_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic              valid_q;
  logic [PAY_W-1:0]  data_q;
  logic [RD_W-1:0]   rd_q;
  logic [CTRL_W-1:0] ctrl_q;

  // Slot register: clear wins over load
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      rd_q    <= rd_i;
      ctrl_q  <= ctrl_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign rd_o    = rd_q;
  assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// flush (bubble insertion) and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_D,
  parameter int unsigned NUM_DATA = NUM_DATA_D,
  parameter int unsigned RD_W     = RD_W_D,
  parameter int unsigned CTRL_W   = CTRL_W_D,
  parameter int unsigned SKID     = 1,
  parameter int unsigned CNT_W    = CNT_W_D
) (
  input  logic           clock,
  input  logic           rst,
  pipe_stage_reg_if.slave bus
);

  localparam int unsigned PAY_W = NUM_DATA * DATA_W;

  pipe_state_e       state_q, state_d;
  logic              in_ready;
  logic              in_fire, out_fire;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;

  logic              main_valid;
  logic [PAY_W-1:0]  main_data;
  logic [RD_W-1:0]   main_rd;
  logic [CTRL_W-1:0] main_ctrl;
  logic [PAY_W-1:0]  main_data_d;
  logic [RD_W-1:0]   main_rd_d;
  logic [CTRL_W-1:0] main_ctrl_d;

  logic              skid_valid;
  logic [PAY_W-1:0]  skid_data;
  logic [RD_W-1:0]   skid_rd;
  logic [CTRL_W-1:0] skid_ctrl;

  logic [CNT_W-1:0]  stall_cnt_q;

  assign in_fire  = bus.in_valid & in_ready;
  assign out_fire = main_valid & bus.out_ready;

  // State register
  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next state and slot controls; flush overrides every handshake
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (bus.flush) begin
      state_d    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && (SKID != 0)) begin
            state_d   = ST_SKID;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d    = ST_EMPTY;
            main_clear = 1'b1;
          end
        end
        ST_SKID: begin
          if (out_fire && skid_valid) begin
            state_d        = ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_d    = ST_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // Main slot refills from the skid entry when one is parked, else from upstream
  always_comb begin
    main_data_d = bus.in_data;
    main_rd_d   = bus.in_rd;
    main_ctrl_d = bus.in_ctrl;
    if (main_from_skid) begin
      main_data_d = skid_data;
      main_rd_d   = skid_rd;
      main_ctrl_d = skid_ctrl;
    end
  end

  pipe_entry #(.PAY_W(PAY_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_main (
    .clock   (clock),
    .rst     (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_data_d),
    .rd_i    (main_rd_d),
    .ctrl_i  (main_ctrl_d),
    .valid_o (main_valid),
    .data_o  (main_data),
    .rd_o    (main_rd),
    .ctrl_o  (main_ctrl)
  );

  if (SKID != 0) begin : g_skid
    logic in_ready_q;

    // Registered ready: low only while both slots will be occupied
    always_ff @(posedge clock or posedge rst) begin
      if (rst) in_ready_q <= 1'b1;
      else     in_ready_q <= (state_d != ST_SKID);
    end

    assign in_ready = in_ready_q;

    pipe_entry #(.PAY_W(PAY_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_skid (
      .clock   (clock),
      .rst     (rst),
      .load_i  (skid_load),
      .clear_i (skid_clear),
      .data_i  (bus.in_data),
      .rd_i    (bus.in_rd),
      .ctrl_i  (bus.in_ctrl),
      .valid_o (skid_valid),
      .data_o  (skid_data),
      .rd_o    (skid_rd),
      .ctrl_o  (skid_ctrl)
    );
  end else begin : g_noskid
    logic unused_skid_ctl;

    // Single slot: accept whenever the held beat is leaving or there is none
    assign in_ready        = ~main_valid | bus.out_ready;
    assign skid_valid      = 1'b0;
    assign skid_data       = '0;
    assign skid_rd         = '0;
    assign skid_ctrl       = '0;
    assign unused_skid_ctl = skid_load ^ skid_clear;
  end

  // Saturating count of cycles the held beat is blocked downstream; only reset clears it
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (main_valid && !bus.out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = main_valid;
  assign bus.out_data  = main_data;
  assign bus.out_rd    = main_rd;
  assign bus.out_ctrl  = main_ctrl;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
